// File: rtl/opsel_pkg.sv
// opsel_pkg: shared definitions for the operand select pipeline.
//   state_t   - pipeline FSM state (EMPTY: no operand held, HOLD: operand on dout)
//   one_code  - select code that yields the constant one (equals NUM_SRC)
//   zero_code - select code that yields the constant zero (equals NUM_SRC+1)
package opsel_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int unsigned one_code(input int unsigned num_src);
    return num_src;
  endfunction

  function automatic int unsigned zero_code(input int unsigned num_src);
    return num_src + 1;
  endfunction

endpackage

// File: rtl/operand_decode.sv
// operand_decode: combinational operand source decode.
//   src   - NUM_SRC channels of WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   sel   - select code: < NUM_SRC picks a channel, NUM_SRC gives constant one,
//           any other code (including out-of-range) gives zero
//   value - decoded operand
module operand_decode #(
  parameter int WIDTH   = 4,
  parameter int NUM_SRC = 2,
  localparam int SEL_W  = $clog2(NUM_SRC + 2)
) (
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         value
);
  import opsel_pkg::*;

  always_comb begin
    value = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        value = src[k*WIDTH +: WIDTH];
      end
    end
    if (sel == SEL_W'(one_code(NUM_SRC))) begin
      value = WIDTH'(1);
    end
  end

endmodule

// File: rtl/operand_select_pipe.sv
// operand_select_pipe: accepts a (select, repeat) command, latches the decoded
// operand and presents it on dout for in_rpt+1 beats with valid/ready handshakes.
//   clk, rst           - clock, asynchronous active-high reset
//   src                - flattened source channels
//   in_sel, in_rpt     - command: source select code and repeat count
//   in_inv             - invert operand at accept (only with OPSEL_COMPLEMENT_EN)
//   in_valid, in_ready - command handshake
//   dout, out_beat     - held operand and current beat index
//   out_last           - current beat is the final repeat
//   out_valid, out_ready - beat handshake
// Build option: define OPSEL_COMPLEMENT_EN to add the in_inv port.
module operand_select_pipe #(
  parameter int WIDTH   = 4,
  parameter int NUM_SRC = 2,
  parameter int RPT_W   = 4,
  localparam int SEL_W  = $clog2(NUM_SRC + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [RPT_W-1:0]         in_rpt,
`ifdef OPSEL_COMPLEMENT_EN
  input  logic                     in_inv,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         dout,
  output logic [RPT_W-1:0]         out_beat,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);
  import opsel_pkg::*;

  state_t           state;
  logic [RPT_W-1:0] rem_cnt;
  logic [WIDTH-1:0] dec_value;
  logic [WIDTH-1:0] operand;
  logic             accept;
  logic             consume;

  operand_decode #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC)
  ) u_decode (
    .src  (src),
    .sel  (in_sel),
    .value(dec_value)
  );

`ifdef OPSEL_COMPLEMENT_EN
  assign operand = in_inv ? ~dec_value : dec_value;
`else
  assign operand = dec_value;
`endif

  assign out_valid = (state == HOLD);
  assign out_last  = (state == HOLD) && (rem_cnt == '0);
  assign consume   = out_valid && out_ready;
  // Refill in the same cycle the last beat leaves: out_ready reaches in_ready combinationally.
  assign in_ready  = (state == EMPTY) || (consume && out_last);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      dout     <= '0;
      out_beat <= '0;
      rem_cnt  <= '0;
    end else if (accept) begin
      state    <= HOLD;
      dout     <= operand;
      out_beat <= '0;
      rem_cnt  <= in_rpt;
    end else if (consume) begin
      if (rem_cnt != '0) begin
        rem_cnt  <= rem_cnt - RPT_W'(1);
        out_beat <= out_beat + RPT_W'(1);
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_operand_select_pipe.sv
// tb_operand_select_pipe: self-checking bench for operand_select_pipe.
// A queue of expected beats (one entry per emitted beat) is the reference model.
// Build option: define OPSEL_COMPLEMENT_EN to exercise in_inv.
module tb_operand_select_pipe;
  localparam int WIDTH   = 4;
  localparam int NUM_SRC = 2;
  localparam int RPT_W   = 4;
  localparam int SEL_W   = $clog2(NUM_SRC + 2);

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_SRC*WIDTH-1:0] src = '0;
  logic [SEL_W-1:0]         in_sel = '0;
  logic [RPT_W-1:0]         in_rpt = '0;
  logic                     in_inv = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     out_ready = 1'b0;
  logic                     in_ready;
  logic [WIDTH-1:0]         dout;
  logic [RPT_W-1:0]         out_beat;
  logic                     out_last;
  logic                     out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] val;
    int               beat;
    bit               last;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  operand_select_pipe #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC),
    .RPT_W  (RPT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .in_sel   (in_sel),
    .in_rpt   (in_rpt),
`ifdef OPSEL_COMPLEMENT_EN
    .in_inv   (in_inv),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .out_beat (out_beat),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_value(input int sel);
    logic [WIDTH-1:0] r;
    if (sel < NUM_SRC) r = src[sel*WIDTH +: WIDTH];
    else if (sel == NUM_SRC) r = 1;
    else r = 0;
    return r;
  endfunction

  function automatic bit exp_valid();
    return q.size() != 0;
  endfunction

  function automatic bit exp_last();
    return (q.size() != 0) && q[0].last;
  endfunction

  function automatic bit exp_ready();
    return (q.size() == 0) || (out_ready && q[0].last);
  endfunction

  // Apply inputs for one cycle; outputs are sampled 1 time unit after negedge.
  task automatic drive(input logic v, input int sel, input int rpt, input logic inv,
                       input logic ordy, input logic [NUM_SRC*WIDTH-1:0] s);
    @(negedge clk);
    in_valid  = v;
    in_sel    = SEL_W'(sel);
    in_rpt    = RPT_W'(rpt);
    in_inv    = inv;
    out_ready = ordy;
    src       = s;
    #1;
  endtask

  // Update the model to the state after the coming rising edge.
  task automatic advance();
    bit consume = (q.size() != 0) && out_ready;
    bit accept  = in_valid && ((q.size() == 0) || (consume && q[0].last));
    logic [WIDTH-1:0] v;
    if (consume) void'(q.pop_front());
    if (accept) begin
      v = ref_value(int'(in_sel));
`ifdef OPSEL_COMPLEMENT_EN
      if (in_inv) v = ~v;
`endif
      for (int i = 0; i <= int'(in_rpt); i++) q.push_back('{v, i, i == int'(in_rpt)});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset dout got %h want 0", dout); end
    n_checks++; if (out_beat !== '0) begin n_fail++; $display("FAIL reset out_beat got %0d want 0", out_beat); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last got %b want 0", out_last); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    q.delete();
  endtask

  task automatic test_single();
    int          sels[4] = '{1, 2, 3, 0};
    logic [3:0]  want[4] = '{4'hA, 4'h1, 4'h0, 4'h5};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, sels[i], 0, 1'b0, 1'b1, {4'hA, 4'h5});
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single idle out_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single in_ready got %b want 1", in_ready); end
      advance();
      drive(1'b0, 0, 0, 1'b0, 1'b1, {4'hA, 4'h5});
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single out_valid sel=%0d got %b want 1", sels[i], out_valid); end
      n_checks++; if (dout !== want[i]) begin n_fail++; $display("FAIL single dout sel=%0d got %h want %h", sels[i], dout, want[i]); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL single out_last got %b want 1", out_last); end
      n_checks++; if (out_beat !== '0) begin n_fail++; $display("FAIL single out_beat got %0d want 0", out_beat); end
      advance();
    end
  endtask

  task automatic test_repeat_stall();
    int consumed = 0;
    logic ordy = 1'b1;
    drive(1'b1, 1, 3, 1'b0, 1'b0, {4'hA, 4'h5});
    advance();
    for (int c = 0; c < 12 && consumed < 4; c++) begin
      drive(1'b0, 0, 0, 1'b0, ordy, {4'h3, 4'hC});
      n_checks++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL stall out_valid got %b want %b", out_valid, exp_valid()); end
      n_checks++; if (out_last !== exp_last()) begin n_fail++; $display("FAIL stall out_last got %b want %b", out_last, exp_last()); end
      if (exp_valid()) begin
        n_checks++; if (dout !== 4'hA) begin n_fail++; $display("FAIL stall dout got %h want a", dout); end
        n_checks++; if (out_beat !== RPT_W'(consumed)) begin n_fail++; $display("FAIL stall out_beat got %0d want %0d", out_beat, consumed); end
        if (ordy) consumed++;
      end
      advance();
      ordy = ~ordy;
    end
    n_checks++; if (consumed != 4 || q.size() != 0) begin n_fail++; $display("FAIL stall beats got %0d want 4", consumed); end
  endtask

  task automatic test_src_change();
    drive(1'b1, 0, 2, 1'b0, 1'b0, {4'h1, 4'h9});
    advance();
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b1, NUM_SRC*WIDTH'($urandom));
      n_checks++; if (dout !== 4'h9) begin n_fail++; $display("FAIL src_change dout got %h want 9", dout); end
      advance();
    end
  endtask

  task automatic test_max_rpt();
    int consumed = 0;
    drive(1'b1, 2, (1 << RPT_W) - 1, 1'b0, 1'b1, '0);
    advance();
    for (int c = 0; c < 24 && q.size() != 0; c++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b1, '0);
      n_checks++; if (out_beat !== RPT_W'(q[0].beat)) begin n_fail++; $display("FAIL max_rpt out_beat got %0d want %0d", out_beat, q[0].beat); end
      n_checks++; if (out_last !== exp_last()) begin n_fail++; $display("FAIL max_rpt out_last got %b want %b beat %0d", out_last, exp_last(), q[0].beat); end
      consumed++;
      advance();
    end
    n_checks++; if (consumed != (1 << RPT_W)) begin n_fail++; $display("FAIL max_rpt beats got %0d want %0d", consumed, 1 << RPT_W); end
    drive(1'b0, 0, 0, 1'b0, 1'b1, '0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL max_rpt after out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int  sels[6];
    int  rpts[6];
    int  idx = 0;
    bit  started = 0;
    for (int i = 0; i < 6; i++) begin
      sels[i] = $urandom_range(0, 3);
      rpts[i] = $urandom_range(0, 2);
    end
    for (int c = 0; c < 60 && (idx < 6 || q.size() != 0); c++) begin
      drive(idx < 6, idx < 6 ? sels[idx] : 0, idx < 6 ? rpts[idx] : 0, 1'b0, 1'b1, {4'h6, 4'hE});
      n_checks++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL b2b in_ready got %b want %b", in_ready, exp_ready()); end
      n_checks++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL b2b out_valid got %b want %b", out_valid, exp_valid()); end
      if (started && idx < 6) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b bubble out_valid got %b want 1", out_valid); end
      end
      if (exp_valid()) begin
        n_checks++; if (dout !== q[0].val) begin n_fail++; $display("FAIL b2b dout got %h want %h", dout, q[0].val); end
        n_checks++; if (out_beat !== RPT_W'(q[0].beat)) begin n_fail++; $display("FAIL b2b out_beat got %0d want %0d", out_beat, q[0].beat); end
        n_checks++; if (out_last !== q[0].last) begin n_fail++; $display("FAIL b2b out_last got %b want %b", out_last, q[0].last); end
      end
      if (idx < 6 && exp_ready()) begin
        idx++;
        started = 1;
      end
      advance();
    end
    n_checks++; if (idx != 6 || q.size() != 0) begin n_fail++; $display("FAIL b2b timeout accepted %0d want 6", idx); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
            1'($urandom), NUM_SRC*WIDTH'($urandom));
      n_checks++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rand in_ready got %b want %b", in_ready, exp_ready()); end
      n_checks++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rand out_valid got %b want %b", out_valid, exp_valid()); end
      n_checks++; if (out_last !== exp_last()) begin n_fail++; $display("FAIL rand out_last got %b want %b", out_last, exp_last()); end
      if (exp_valid()) begin
        n_checks++; if (dout !== q[0].val) begin n_fail++; $display("FAIL rand dout got %h want %h", dout, q[0].val); end
        n_checks++; if (out_beat !== RPT_W'(q[0].beat)) begin n_fail++; $display("FAIL rand out_beat got %0d want %0d", out_beat, q[0].beat); end
      end
      advance();
    end
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b1, '0);
      advance();
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand drain left %0d want 0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1, 5, 1'b0, 1'b0, {4'hA, 4'h5});
    advance();
    repeat (2) begin
      drive(1'b0, 0, 0, 1'b0, 1'b1, {4'hA, 4'h5});
      advance();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0, {4'hA, 4'h5});
    n_checks++; if (out_beat !== RPT_W'(2)) begin n_fail++; $display("FAIL midrst beat got %0d want 2", out_beat); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL midrst dout got %h want 0", dout); end
    n_checks++; if (out_beat !== '0) begin n_fail++; $display("FAIL midrst out_beat got %0d want 0", out_beat); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL midrst out_last got %b want 0", out_last); end
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready got %b want 1", in_ready); end
    drive(1'b1, 0, 1, 1'b0, 1'b1, {4'hA, 4'h5});
    advance();
    drive(1'b0, 0, 0, 1'b0, 1'b1, {4'hA, 4'h5});
    n_checks++; if (out_beat !== '0) begin n_fail++; $display("FAIL midrst new beat got %0d want 0", out_beat); end
    n_checks++; if (dout !== 4'h5) begin n_fail++; $display("FAIL midrst new dout got %h want 5", dout); end
    advance();
    drive(1'b0, 0, 0, 1'b0, 1'b1, {4'hA, 4'h5});
    advance();
  endtask

`ifdef OPSEL_COMPLEMENT_EN
  task automatic test_complement();
    drive(1'b1, 0, 0, 1'b1, 1'b1, {4'hA, 4'h5});
    advance();
    drive(1'b0, 0, 0, 1'b0, 1'b1, {4'hA, 4'h5});
    n_checks++; if (dout !== 4'hA) begin n_fail++; $display("FAIL complement dout got %h want a", dout); end
    advance();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_repeat_stall();
    test_src_change();
    test_max_rpt();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef OPSEL_COMPLEMENT_EN
    test_complement();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
